l2_port_arbiter: RTL
====================

// Module: l2_port_arbiter
// PURPOSE
//  Shares the single L2/lower-memory port between the L1 instruction cache (read-only) and
//  the L1 data cache (read/write). Round-robin arbitration, one outstanding transaction;
//  the grant is held until the L2 completes or a watchdog timeout fires. Sits between the
//  L1 caches and L2, replacing each cache's direct l2_* connection.
// PARAMETERS
//  ADDR_WIDTH  32   address width of all request/L2 address buses
//  DATA_WIDTH  32   width of write/response data buses
//  TIMEOUT     255  cycles to wait for l2_ready before aborting; 0 disables watchdog
// PORTS
//  clk              in   1           clock
//  reset            in   1           asynchronous, active-high reset
//  i_req            in   1           I-cache request, level; held until i_ready
//  i_addr           in   ADDR_WIDTH  I-cache read address
//  i_rdata          out  DATA_WIDTH  read data to I-cache, valid with i_ready
//  i_ready          out  1           one-cycle completion pulse to I-cache
//  i_err            out  1           with i_ready: transaction timed out
//  d_req            in   1           D-cache request, level; held until d_ready
//  d_we             in   1           D-cache write (1) / read (0)
//  d_addr           in   ADDR_WIDTH  D-cache address
//  d_wdata          in   DATA_WIDTH  D-cache write data (writeback)
//  d_rdata          out  DATA_WIDTH  read data to D-cache, valid with d_ready
//  d_ready          out  1           one-cycle completion pulse to D-cache
//  d_err            out  1           with d_ready: transaction timed out
//  l2_request       out  1           request to L2, held until l2_ready or timeout
//  l2_write_enable  out  1           L2 write (1) / read (0)
//  l2_address       out  ADDR_WIDTH  L2 address
//  l2_write_data    out  DATA_WIDTH  L2 write data
//  l2_response_data in   DATA_WIDTH  L2 read data, sampled when l2_ready=1
//  l2_ready         in   1           L2 completion, sampled only while l2_request=1
//  arb_state        out  2           debug: 0 IDLE, 1 BUSY, 2 RESP
// BEHAVIOUR
//  - All outputs registered. Reset: all outputs 0, state IDLE, owner=none, last_grant=I
//    (D-cache wins first tie), timeout counter 0. Reset mid-transaction aborts it; l2_request
//    drops asynchronously; no ready pulse is issued for the aborted transaction.
//  - IDLE: if any req, grant; on tie grant requester other than last_grant. At grant edge
//    latch addr/we/wdata into l2_* regs (I: l2_write_enable=0, l2_write_data=0), set
//    l2_request=1, owner, last_grant, counter=0 -> BUSY. No req: stay IDLE.
//  - BUSY: l2_* held stable. Counter increments each cycle, saturating. On l2_ready=1:
//    l2_request<=0, owner rdata<=l2_response_data (0 for writes), owner ready<=1 -> RESP.
//    If TIMEOUT!=0 and counter reaches TIMEOUT-1 with no l2_ready: l2_request<=0, rdata<=0,
//    ready<=1, err<=1 -> RESP. l2_ready and timeout same cycle: l2_ready wins, err=0.
//  - RESP: exactly one cycle; ready/err pulse visible; requests ignored; -> IDLE, ready/err
//    cleared. rdata holds until next completion to that requester.
//  - Latency: req in cycle 0 (IDLE) -> l2_request cycle 1; l2_ready in cycle k -> ready in
//    cycle k+1; next grant evaluated in cycle k+2, its l2_request in cycle k+3.
//  - l2_request always low >=2 cycles between transactions. Non-owner req ignored while
//    BUSY/RESP. Owner dropping req while BUSY does not cancel: transaction completes, pulse
//    still delivered. Requester may drop req in IDLE before grant (no effect).
//  - Only one of i_ready/d_ready high in any cycle; the non-owner's outputs never change.
// TESTING
//  - Single D read: d_req,d_we=0,d_addr=0x1000; L2 ready 3 cycles later data 0xDEADBEEF ->
//    l2_address=0x1000 cycle 1, d_ready pulse 1 cycle with d_rdata=0xDEADBEEF, d_err=0.
//  - Tie after reset: i_req,d_req same cycle -> D granted first; I granted next; with both
//    held, grants alternate D,I,D,I over 4 transactions.
//  - D writeback: d_we=1,d_addr=0x2000,d_wdata=0xA5A5A5A5 -> l2_write_enable=1, data
//    0xA5A5A5A5; I request 0x40 arriving mid-transaction served only after d_ready+RESP.
//  - Timeout: TIMEOUT=8, L2 never ready -> l2_request high exactly 8 cycles, then
//    i_ready=1,i_err=1,i_rdata=0; next request proceeds normally.
//  - Reset asserted while BUSY -> l2_request 0 immediately, no ready pulse; after release
//    first tie goes to D.
//  - l2_ready in the cycle counter hits TIMEOUT-1 -> normal completion, err=0, data passed.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-cache and the L1 D-cache.
// It allows one outstanding transaction, and a watchdog aborts an L2 access that never completes.
module l2_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    output logic                  i_err,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  d_err,

    output logic                  l2_request,
    output logic                  l2_write_enable,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [DATA_WIDTH-1:0] l2_write_data,
    input  logic [DATA_WIDTH-1:0] l2_response_data,
    input  logic                  l2_ready,

    output logic [1:0]            arb_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    // The counter only needs to reach TIMEOUT-1 and saturates at all-ones beyond that.
    localparam int CNT_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [1:0]           state;
    logic [1:0]           owner;
    logic                 last_grant_d;
    logic [CNT_WIDTH-1:0] count;

    logic                  grant_i;
    logic                  grant_d;
    logic                  timed_out;
    logic                  complete;
    logic                  abort;
    logic [DATA_WIDTH-1:0] resp_data;

    // On a tie, the requester that was not granted last wins.
    assign grant_d   = d_req && (!i_req || !last_grant_d);
    assign grant_i   = i_req && !grant_d;
    assign timed_out = (TIMEOUT != 0) && (count == CNT_LAST);
    assign complete  = (state == ST_BUSY) && (l2_ready || timed_out);
    assign abort     = complete && !l2_ready;
    assign resp_data = (abort || l2_write_enable) ? '0 : l2_response_data;

    assign arb_state = state;

    // NOTE: state elements use non-blocking assignments, so every block samples the
    // pre-edge values and the order in which the blocks are written does not matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            owner        <= OWN_NONE;
            last_grant_d <= 1'b0;
            count        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_i || grant_d) begin
                        state        <= ST_BUSY;
                        owner        <= grant_d ? OWN_D : OWN_I;
                        last_grant_d <= grant_d;
                        count        <= '0;
                    end
                end
                ST_BUSY: begin
                    if (complete) begin
                        state <= ST_RESP;
                    end else if (count != CNT_MAX) begin
                        count <= count + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    // The L2 command registers are loaded only at the grant edge and stay stable while the transaction is outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2_request      <= 1'b0;
            l2_write_enable <= 1'b0;
            l2_address      <= '0;
            l2_write_data   <= '0;
        end else if ((state == ST_IDLE) && (grant_i || grant_d)) begin
            l2_request      <= 1'b1;
            l2_write_enable <= grant_d && d_we;
            l2_address      <= grant_d ? d_addr : i_addr;
            l2_write_data   <= grant_d ? d_wdata : '0;
        end else if (complete) begin
            l2_request <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rdata <= '0;
            i_ready <= 1'b0;
            i_err   <= 1'b0;
        end else if (complete && (owner == OWN_I)) begin
            i_rdata <= resp_data;
            i_ready <= 1'b1;
            i_err   <= abort;
        end else if (state == ST_RESP) begin
            i_ready <= 1'b0;
            i_err   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_rdata <= '0;
            d_ready <= 1'b0;
            d_err   <= 1'b0;
        end else if (complete && (owner == OWN_D)) begin
            d_rdata <= resp_data;
            d_ready <= 1'b1;
            d_err   <= abort;
        end else if (state == ST_RESP) begin
            d_ready <= 1'b0;
            d_err   <= 1'b0;
        end
    end

endmodule
